// File: rtl/envelope_shift_generator.sv
// ADSR envelope generator whose level is a right-shift attenuation:
// 0 is full scale, all-ones is silent. Each stepping phase advances the
// shift by one every <phase>_period clocks; a key gate drives the phases.
module envelope_shift_generator #(
   parameter int unsigned SHIFT_W = 4,
   parameter int unsigned RATE_W  = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               gate,
   input  logic [RATE_W-1:0]  attack_period,
   input  logic [RATE_W-1:0]  decay_period,
   input  logic [SHIFT_W-1:0] sustain_shift,
   input  logic [RATE_W-1:0]  release_period,
   output logic [SHIFT_W-1:0] shift_amount,
   output logic [2:0]         phase,
   output logic               active,
   output logic               done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } phase_t;

   localparam logic [SHIFT_W-1:0] SHIFT_MAX = '1;
   localparam logic [SHIFT_W-1:0] ONE_S     = SHIFT_W'(1);
   localparam logic [RATE_W-1:0]  ONE_R     = RATE_W'(1);

   phase_t             state;
   logic [SHIFT_W-1:0] shift_q;
   logic [SHIFT_W-1:0] sustain_q;
   logic [RATE_W-1:0]  cnt;
   logic [RATE_W-1:0]  cur_period;
   logic               step_hit;

   assign shift_amount = shift_q;
   assign phase        = state;
   assign active       = (state != IDLE);

   // Select the live period of the current phase and decide whether this edge steps.
   always_comb begin
      cur_period = '0;
      case (state)
         ATTACK:  cur_period = attack_period;
         DECAY:   cur_period = decay_period;
         RELEASE: cur_period = release_period;
         default: cur_period = '0;
      endcase
      // Periods 0 and 1 both step every edge; >= lets a shortened period act at once.
      step_hit = (cur_period <= ONE_R) ? 1'b1 : (cnt >= (cur_period - ONE_R));
   end

   // Phase sequencing, step divider, shift level and done pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         shift_q   <= SHIFT_MAX;
         sustain_q <= '0;
         cnt       <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               shift_q <= SHIFT_MAX;
               cnt     <= '0;
               if (gate) begin
                  state <= ATTACK;
               end
            end

            ATTACK: begin
               if (!gate) begin
                  state <= RELEASE;
                  cnt   <= '0;
               end else if (step_hit) begin
                  cnt <= '0;
                  if (shift_q <= ONE_S) begin
                     shift_q   <= '0;
                     sustain_q <= sustain_shift;
                     state     <= (sustain_shift != '0) ? DECAY : SUSTAIN;
                  end else begin
                     shift_q <= shift_q - ONE_S;
                  end
               end else begin
                  cnt <= cnt + ONE_R;
               end
            end

            DECAY: begin
               if (!gate) begin
                  state <= RELEASE;
                  cnt   <= '0;
               end else if (step_hit) begin
                  cnt <= '0;
                  if ((shift_q < sustain_q) && ((sustain_q - shift_q) > ONE_S)) begin
                     shift_q <= shift_q + ONE_S;
                  end else begin
                     shift_q <= sustain_q;
                     state   <= SUSTAIN;
                  end
               end else begin
                  cnt <= cnt + ONE_R;
               end
            end

            SUSTAIN: begin
               cnt <= '0;
               if (!gate) begin
                  state <= RELEASE;
               end
            end

            RELEASE: begin
               if (gate) begin
                  state <= ATTACK;
                  cnt   <= '0;
               end else if (shift_q == SHIFT_MAX) begin
                  state <= IDLE;
                  done  <= 1'b1;
                  cnt   <= '0;
               end else if (step_hit) begin
                  cnt     <= '0;
                  shift_q <= shift_q + ONE_S;
                  if (shift_q == (SHIFT_MAX - ONE_S)) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + ONE_R;
               end
            end

            default: begin
               state   <= IDLE;
               shift_q <= SHIFT_MAX;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_envelope_shift_generator.sv
// Scoreboard bench for envelope_shift_generator (SHIFT_W=4). The driver
// applies inputs on the falling edge and queues the hand-derived outputs
// expected after the next rising edge; the monitor checks them after it.
module tb_envelope_shift_generator;

   logic        clock;
   logic        reset;
   logic        gate;
   logic [31:0] attack_period;
   logic [31:0] decay_period;
   logic [3:0]  sustain_shift;
   logic [31:0] release_period;
   logic [3:0]  shift_amount;
   logic [2:0]  phase;
   logic        active;
   logic        done;

   envelope_shift_generator #(.SHIFT_W(4), .RATE_W(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .gate           (gate),
      .attack_period  (attack_period),
      .decay_period   (decay_period),
      .sustain_shift  (sustain_shift),
      .release_period (release_period),
      .shift_amount   (shift_amount),
      .phase          (phase),
      .active         (active),
      .done           (done)
   );

   typedef struct {
      bit    chk;
      int    sh;
      int    ph;
      bit    dn;
      string name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One cycle of stimulus plus the outputs expected after the next rising edge.
   task automatic cyc(input bit g, input bit r, input bit chk,
                      input int sh, input int ph, input bit dn, input string name);
      exp_t e;
      @(negedge clock);
      gate  = g;
      reset = r;
      e.chk = chk; e.sh = sh; e.ph = ph; e.dn = dn; e.name = name;
      sb.push_back(e);
   endtask

   // Monitor: compare DUT outputs shortly after each rising edge.
   always @(posedge clock) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.chk) begin
            checks++;
            if (int'(shift_amount) != e.sh) begin
               errors++;
               $display("FAIL %s shift got %0d want %0d t=%0t", e.name, shift_amount, e.sh, $time);
            end
            checks++;
            if (int'(phase) != e.ph) begin
               errors++;
               $display("FAIL %s phase got %0d want %0d t=%0t", e.name, phase, e.ph, $time);
            end
            checks++;
            if (done != e.dn) begin
               errors++;
               $display("FAIL %s done got %0d want %0d t=%0t", e.name, done, e.dn, $time);
            end
            checks++;
            if (active != (e.ph != 0)) begin
               errors++;
               $display("FAIL %s active got %0d want %0d t=%0t", e.name, active, (e.ph != 0), $time);
            end
         end
      end
   end

   initial begin
      reset          = 1'b1;
      gate           = 1'b0;
      attack_period  = 32'd1;
      decay_period   = 32'd1;
      release_period = 32'd1;
      sustain_shift  = 4'd6;

      // Reset then idle
      cyc(0, 1, 1, 15, 0, 0, "reset0");
      cyc(0, 1, 1, 15, 0, 0, "reset1");
      for (int i = 0; i < 20; i++) cyc(0, 0, 1, 15, 0, 0, "idle");

      // Full ADSR, all periods 1, sustain 6
      cyc(1, 0, 1, 15, 1, 0, "adsr_entry");
      for (int i = 1; i <= 15; i++) cyc(1, 0, 1, 15 - i, (i == 15) ? 2 : 1, 0, "adsr_attack");
      for (int i = 1; i <= 6; i++) cyc(1, 0, 1, i, (i == 6) ? 3 : 2, 0, "adsr_decay");
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 6, 3, 0, "adsr_sustain");
      cyc(0, 0, 1, 6, 4, 0, "adsr_rel_entry");
      for (int i = 1; i <= 9; i++)
         cyc(0, 0, 1, 6 + i, (i == 9) ? 0 : 4, (i == 9) ? 1'b1 : 1'b0, "adsr_release");
      cyc(0, 0, 1, 15, 0, 0, "adsr_done_once");
      cyc(0, 0, 1, 15, 0, 0, "adsr_idle");

      // Period scaling: attack_period 3
      attack_period = 32'd3;
      cyc(1, 0, 1, 15, 1, 0, "p3_entry");
      cyc(1, 0, 1, 15, 1, 0, "p3_e1");
      cyc(1, 0, 1, 15, 1, 0, "p3_e2");
      cyc(1, 0, 1, 14, 1, 0, "p3_e3");
      cyc(1, 0, 1, 14, 1, 0, "p3_e4");
      cyc(1, 0, 1, 14, 1, 0, "p3_e5");
      cyc(1, 0, 1, 13, 1, 0, "p3_e6");
      cyc(1, 1, 1, 15, 0, 0, "p3_reset");

      // attack_period 0 acts as 1
      attack_period = 32'd0;
      cyc(1, 0, 1, 15, 1, 0, "p0_entry");
      cyc(1, 0, 1, 14, 1, 0, "p0_e1");
      cyc(1, 0, 1, 13, 1, 0, "p0_e2");
      cyc(0, 1, 1, 15, 0, 0, "p0_reset");

      // Early release at shift 9, release_period 2
      attack_period  = 32'd1;
      release_period = 32'd2;
      cyc(1, 0, 1, 15, 1, 0, "early_entry");
      for (int i = 1; i <= 6; i++) cyc(1, 0, 1, 15 - i, 1, 0, "early_attack");
      cyc(0, 0, 1, 9, 4, 0, "early_rel_edge");
      for (int j = 1; j <= 12; j++)
         cyc(0, 0, 1, 9 + j / 2, (j == 12) ? 0 : 4, (j == 12) ? 1'b1 : 1'b0, "early_release");
      cyc(0, 0, 1, 15, 0, 0, "early_idle");

      // Retrigger at shift 12 with sustain 0: straight to SUSTAIN, no done
      release_period = 32'd1;
      sustain_shift  = 4'd0;
      cyc(1, 0, 1, 15, 1, 0, "retrig_entry");
      for (int i = 1; i <= 3; i++) cyc(1, 0, 1, 15 - i, 1, 0, "retrig_attack");
      cyc(0, 0, 1, 12, 4, 0, "retrig_release");
      cyc(1, 0, 1, 12, 1, 0, "retrig_edge");
      for (int i = 1; i <= 12; i++) cyc(1, 0, 1, 12 - i, (i == 12) ? 3 : 1, 0, "retrig_attack2");
      cyc(1, 0, 1, 0, 3, 0, "sus0_hold0");
      cyc(1, 0, 1, 0, 3, 0, "sus0_hold1");

      // Reset in SUSTAIN with gate held, then ATTACK one edge after release
      cyc(1, 1, 1, 15, 0, 0, "sus_reset0");
      cyc(1, 1, 1, 15, 0, 0, "sus_reset1");
      cyc(1, 0, 1, 15, 1, 0, "post_reset_entry");
      cyc(1, 0, 1, 14, 1, 0, "post_reset_step");
      cyc(0, 1, 1, 15, 0, 0, "final_reset");

      // Drain: every queued expectation must have been consumed
      @(posedge clock);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain queue got %0d want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
